// File: rtl/l2_mem_arbiter_if.sv
// l2_mem_arbiter_if: bundle of the L1-side and memory-side signals of the L2 memory arbiter.
//   slave  modport: the arbiter (takes requests and memory responses, drives grants and data)
//   master modport: the environment (I-cache, D-cache, prefetcher and physical memory)
// Signals:
//   i_*   I-cache line read port          d_*  D-cache line read / writeback port
//   p_*   next-line prefetcher port       mem_* single line-wide physical memory port
interface l2_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  p_read;
    logic [ADDR_WIDTH-1:0] p_address;
    logic                  p_grant;
    logic [LINE_WIDTH-1:0] p_rdata;
    logic                  p_resp;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
        input  p_read, p_address, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, p_grant, p_rdata, p_resp,
        output mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
        output p_read, p_address, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, p_grant, p_rdata, p_resp,
        input  mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter: shares one line-wide physical memory port between I-cache miss fills,
// D-cache fills/writebacks and the next-line prefetcher.
//   - I and D demand requests are arbitrated round-robin; prefetch only goes when no demand waits.
//   - One memory transaction at a time; a one-cycle RELEASE follows every completion.
//   - An I-cache miss to the line being prefetched completes with that prefetch's response.
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    l2_mem_arbiter_if.slave (cache, prefetcher and memory signals)
module l2_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256
) (
    input logic              clk,
    input logic              reset,
    l2_mem_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle,
        StServeI,
        StServeD,
        StServeP,
        StRelease
    } state_e;

    state_e                r_state;
    logic                  r_last_d;     // 1: D was served last, so I wins the next tie
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic                  r_mem_read;   // also serves as the latched op of the transaction
    logic                  r_mem_write;

    logic w_d_req;
    logic w_grant_i;
    logic w_grant_d;
    logic w_grant_p;
    logic w_merge;

    assign w_d_req = bus.d_read | bus.d_write;

    // IDLE arbitration: demand beats prefetch, ties between I and D alternate.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        w_grant_p = 1'b0;
        if (r_state == StIdle) begin
            if (bus.i_read && w_d_req) begin
                w_grant_i = r_last_d;
                w_grant_d = ~r_last_d;
            end else if (bus.i_read) begin
                w_grant_i = 1'b1;
            end else if (w_d_req) begin
                w_grant_d = 1'b1;
            end else if (bus.p_read) begin
                w_grant_p = 1'b1;
            end
        end
    end

    // I-cache miss to the line already being prefetched rides on the prefetch response.
    assign w_merge = (r_state == StServeP) && bus.i_read && (bus.i_address == r_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_last_d    <= 1'b1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_grant_i) begin
                        r_addr      <= bus.i_address;
                        r_mem_read  <= 1'b1;
                        r_mem_write <= 1'b0;
                        r_state     <= StServeI;
                    end else if (w_grant_d) begin
                        // d_read together with d_write is treated as a writeback.
                        r_addr      <= bus.d_address;
                        r_wdata     <= bus.d_wdata;
                        r_mem_read  <= ~bus.d_write;
                        r_mem_write <= bus.d_write;
                        r_state     <= StServeD;
                    end else if (w_grant_p) begin
                        r_addr      <= bus.p_address;
                        r_mem_read  <= 1'b1;
                        r_mem_write <= 1'b0;
                        r_state     <= StServeP;
                    end
                end
                StServeI, StServeD, StServeP: begin
                    if (bus.mem_resp) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= StRelease;
                        if (r_state == StServeI) begin
                            r_last_d <= 1'b0;
                        end else if (r_state == StServeD) begin
                            r_last_d <= 1'b1;
                        end
                    end
                end
                StRelease: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Completion pulses are combinational on mem_resp and only reach the granted requester(s).
    assign bus.i_resp  = ~reset & bus.mem_resp & ((r_state == StServeI) | w_merge);
    assign bus.d_resp  = ~reset & bus.mem_resp & (r_state == StServeD);
    assign bus.p_resp  = ~reset & bus.mem_resp & (r_state == StServeP);
    assign bus.p_grant = ~reset & w_grant_p;

    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;
    assign bus.p_rdata = bus.mem_rdata;

    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_address = r_addr;
    assign bus.mem_wdata   = r_wdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(bus.d_read && bus.d_write))
            else $error("l2_mem_arbiter: d_read and d_write asserted together");
        end
    end

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// tb_l2_mem_arbiter: directed scenarios followed by randomized traffic from I, D and prefetch
// requesters against a transaction-level model of the arbitration rules and a line memory.
module tb_l2_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;

    typedef enum int {OwnNone, OwnI, OwnD, OwnP} own_e;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    l2_mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    l2_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [LW-1:0] phys [logic [AW-1:0]];

    // Random-phase model state
    own_e          m_owner;
    own_e          g;
    bit            m_rel;
    bit            m_last_d;
    bit            m_wr;
    bit            merge;
    bit            resp_now;
    int            m_cnt;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    bit            ip, dp, dw, pp;
    logic [AW-1:0] ia, da, pa;
    logic [LW-1:0] dwd;
    int            n;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        return {8{a ^ 32'hA5A5_0000}};
    endfunction

    function automatic logic [LW-1:0] phys_rd(input logic [AW-1:0] a);
        if (phys.exists(a)) return phys[a];
        return line_of(a);
    endfunction

    function automatic logic [AW-1:0] pick();
        return 32'h1000 + 32'h20 * $urandom_range(0, 3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_read    = 1'b0;
        bus.i_address = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_address = '0;
        bus.d_wdata   = '0;
        bus.p_read    = 1'b0;
        bus.p_address = '0;
        bus.mem_rdata = '0;
        bus.mem_resp  = 1'b0;
    endtask

    // Leaves the caller at the first post-reset cycle, inputs idle, ready to drive.
    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        #1;
        chk1("rst_i_resp", bus.i_resp, 1'b0);
        chk1("rst_d_resp", bus.d_resp, 1'b0);
        chk1("rst_p_resp", bus.p_resp, 1'b0);
        chk1("rst_p_grant", bus.p_grant, 1'b0);
        chk1("rst_mem_read", bus.mem_read, 1'b0);
        chk1("rst_mem_write", bus.mem_write, 1'b0);
        chka("rst_mem_address", bus.mem_address, 32'h0);
        chkw("rst_mem_wdata", bus.mem_wdata, '0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Isolated I miss, then a D request raised during RELEASE.
        do_reset();
        bus.i_read = 1'b1; bus.i_address = 32'h100; #1;
        chk1("iso_c0_mem_read", bus.mem_read, 1'b0);
        tick(); #1;
        chk1("iso_c1_mem_read", bus.mem_read, 1'b1);
        chka("iso_c1_addr", bus.mem_address, 32'h100);
        tick(); tick(); tick(); #1;
        chk1("iso_c4_mem_read", bus.mem_read, 1'b1);
        chk1("iso_c4_no_resp", bus.i_resp, 1'b0);
        tick(); bus.mem_resp = 1'b1; bus.mem_rdata = line_of(32'h100); #1;
        chk1("iso_c5_i_resp", bus.i_resp, 1'b1);
        chkw("iso_c5_i_rdata", bus.i_rdata, line_of(32'h100));
        chk1("iso_c5_d_resp", bus.d_resp, 1'b0);
        chk1("iso_c5_p_resp", bus.p_resp, 1'b0);
        tick(); bus.mem_resp = 1'b0; bus.i_read = 1'b0;
        bus.d_read = 1'b1; bus.d_address = 32'h180; #1;
        chk1("iso_c6_release_mem_read", bus.mem_read, 1'b0);
        chk1("iso_c6_i_resp", bus.i_resp, 1'b0);
        tick(); #1;
        chk1("iso_c7_idle_mem_read", bus.mem_read, 1'b0);
        tick(); #1;
        chk1("iso_c8_mem_read", bus.mem_read, 1'b1);
        chka("iso_c8_addr", bus.mem_address, 32'h180);
        tick(); bus.mem_resp = 1'b1; bus.mem_rdata = line_of(32'h180); #1;
        chk1("iso_c9_d_resp", bus.d_resp, 1'b1);
        chk1("iso_c9_i_resp", bus.i_resp, 1'b0);
        chkw("iso_c9_d_rdata", bus.d_rdata, line_of(32'h180));
        tick(); bus.mem_resp = 1'b0; bus.d_read = 1'b0;

        // Simultaneous I read and D write after reset: I first, then the writeback.
        do_reset();
        bus.i_read = 1'b1; bus.i_address = 32'h200;
        bus.d_write = 1'b1; bus.d_address = 32'h300; bus.d_wdata = {8{32'hDEAD_BEEF}};
        tick(); #1;
        chk1("tie_c1_mem_read", bus.mem_read, 1'b1);
        chk1("tie_c1_mem_write", bus.mem_write, 1'b0);
        chka("tie_c1_addr", bus.mem_address, 32'h200);
        tick(); bus.mem_resp = 1'b1; bus.mem_rdata = line_of(32'h200); #1;
        chk1("tie_c2_i_resp", bus.i_resp, 1'b1);
        chk1("tie_c2_d_resp", bus.d_resp, 1'b0);
        tick(); bus.mem_resp = 1'b0; bus.i_read = 1'b0; #1;
        chk1("tie_c3_mem_read", bus.mem_read, 1'b0);
        chk1("tie_c3_mem_write", bus.mem_write, 1'b0);
        tick(); tick(); #1;
        chk1("tie_c5_mem_write", bus.mem_write, 1'b1);
        chk1("tie_c5_mem_read", bus.mem_read, 1'b0);
        chka("tie_c5_addr", bus.mem_address, 32'h300);
        chkw("tie_c5_wdata", bus.mem_wdata, {8{32'hDEAD_BEEF}});
        tick(); bus.mem_resp = 1'b1; #1;
        chk1("tie_c6_d_resp", bus.d_resp, 1'b1);
        chk1("tie_c6_i_resp", bus.i_resp, 1'b0);
        tick(); bus.mem_resp = 1'b0; bus.d_write = 1'b0;

        // Back-to-back contention: I and D held high for four rounds.
        do_reset();
        bus.i_read = 1'b1; bus.i_address = 32'h500;
        bus.d_read = 1'b1; bus.d_address = 32'h600;
        for (int r = 0; r < 4; r++) begin
            n = 0;
            #1;
            while (!bus.mem_read && n < 8) begin
                tick(); #1;
                n++;
            end
            chk1($sformatf("cont_r%0d_started", r), bus.mem_read, 1'b1);
            chka($sformatf("cont_r%0d_addr", r), bus.mem_address,
                 (r % 2 == 0) ? 32'h500 : 32'h600);
            tick(); bus.mem_resp = 1'b1; bus.mem_rdata = line_of(bus.mem_address); #1;
            chk1($sformatf("cont_r%0d_i_resp", r), bus.i_resp, (r % 2 == 0));
            chk1($sformatf("cont_r%0d_d_resp", r), bus.d_resp, (r % 2 == 1));
            chk1($sformatf("cont_r%0d_p_resp", r), bus.p_resp, 1'b0);
            tick(); bus.mem_resp = 1'b0;
        end
        idle_inputs();

        // Prefetch merge with an I miss to the same line.
        do_reset();
        bus.p_read = 1'b1; bus.p_address = 32'h400; #1;
        chk1("merge_c0_p_grant", bus.p_grant, 1'b1);
        tick(); bus.p_read = 1'b0; bus.i_read = 1'b1; bus.i_address = 32'h400; #1;
        chk1("merge_c1_mem_read", bus.mem_read, 1'b1);
        chka("merge_c1_addr", bus.mem_address, 32'h400);
        chk1("merge_c1_p_grant", bus.p_grant, 1'b0);
        tick(); bus.mem_resp = 1'b1; bus.mem_rdata = line_of(32'h400); #1;
        chk1("merge_c2_i_resp", bus.i_resp, 1'b1);
        chk1("merge_c2_p_resp", bus.p_resp, 1'b1);
        chkw("merge_c2_i_rdata", bus.i_rdata, line_of(32'h400));
        chkw("merge_c2_p_rdata", bus.p_rdata, line_of(32'h400));
        tick(); bus.mem_resp = 1'b0; bus.i_read = 1'b0; #1;
        chk1("merge_c3_mem_read", bus.mem_read, 1'b0);
        tick(); tick(); #1;
        chk1("merge_c5_no_second_read", bus.mem_read, 1'b0);

        // Prefetch yields to a demand read raised in the same cycle.
        do_reset();
        bus.p_read = 1'b1; bus.p_address = 32'h700;
        bus.d_read = 1'b1; bus.d_address = 32'h800; #1;
        chk1("yield_c0_p_grant", bus.p_grant, 1'b0);
        tick(); #1;
        chka("yield_c1_addr", bus.mem_address, 32'h800);
        tick(); bus.mem_resp = 1'b1; bus.mem_rdata = line_of(32'h800); #1;
        chk1("yield_c2_d_resp", bus.d_resp, 1'b1);
        chk1("yield_c2_p_resp", bus.p_resp, 1'b0);
        tick(); bus.mem_resp = 1'b0; bus.d_read = 1'b0; #1;
        chk1("yield_c3_p_grant", bus.p_grant, 1'b0);
        tick(); #1;
        chk1("yield_c4_p_grant", bus.p_grant, 1'b1);
        tick(); bus.p_read = 1'b0; #1;
        chk1("yield_c5_mem_read", bus.mem_read, 1'b1);
        chka("yield_c5_addr", bus.mem_address, 32'h700);
        tick(); bus.mem_resp = 1'b1; bus.mem_rdata = line_of(32'h700); #1;
        chk1("yield_c6_p_resp", bus.p_resp, 1'b1);
        chk1("yield_c6_i_resp", bus.i_resp, 1'b0);
        tick(); bus.mem_resp = 1'b0;

        // Reset while serving D; a late memory response must be dropped.
        do_reset();
        bus.d_read = 1'b1; bus.d_address = 32'h900;
        tick(); #1;
        chk1("rstd_c1_mem_read", bus.mem_read, 1'b1);
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; bus.d_read = 1'b0;
        bus.mem_resp = 1'b1; bus.mem_rdata = line_of(32'h900); #1;
        chk1("rstd_c3_mem_read", bus.mem_read, 1'b0);
        chk1("rstd_c3_d_resp", bus.d_resp, 1'b0);
        chk1("rstd_c3_i_resp", bus.i_resp, 1'b0);
        tick(); bus.mem_resp = 1'b0; bus.i_read = 1'b1; bus.i_address = 32'hA00; #1;
        chk1("rstd_c4_mem_read", bus.mem_read, 1'b0);
        tick(); #1;
        chk1("rstd_c5_mem_read", bus.mem_read, 1'b1);
        chka("rstd_c5_addr", bus.mem_address, 32'hA00);
        tick(); bus.mem_resp = 1'b1; bus.mem_rdata = line_of(32'hA00); #1;
        chk1("rstd_c6_i_resp", bus.i_resp, 1'b1);
        tick(); bus.mem_resp = 1'b0; bus.i_read = 1'b0;

        // Randomized traffic against the transaction-level model.
        do_reset();
        m_owner  = OwnNone;
        m_rel    = 1'b0;
        m_last_d = 1'b1;
        m_wr     = 1'b0;
        m_cnt    = 0;
        m_addr   = '0;
        m_wdata  = '0;
        ip = 1'b0; dp = 1'b0; dw = 1'b0; pp = 1'b0;
        ia = '0; da = '0; pa = '0; dwd = '0;
        for (int c = 0; c < 2000; c++) begin
            if (c != 0) tick();
            bus.i_read    = ip;
            bus.i_address = ia;
            bus.d_read    = dp && !dw;
            bus.d_write   = dp && dw;
            bus.d_address = da;
            bus.d_wdata   = dwd;
            bus.p_read    = pp;
            bus.p_address = pa;
            resp_now      = (m_owner != OwnNone) && (m_cnt == 0);
            bus.mem_resp  = resp_now;
            bus.mem_rdata = resp_now ? phys_rd(m_addr) : {8{$urandom}};
            #1;

            g = OwnNone;
            if (m_owner == OwnNone && !m_rel) begin
                if (ip && dp)  g = m_last_d ? OwnI : OwnD;
                else if (ip)   g = OwnI;
                else if (dp)   g = OwnD;
                else if (pp)   g = OwnP;
            end
            merge = resp_now && (m_owner == OwnP) && ip && (ia == m_addr);

            chk1("rnd_p_grant", bus.p_grant, g == OwnP);
            chk1("rnd_mem_read", bus.mem_read, (m_owner != OwnNone) && !m_wr);
            chk1("rnd_mem_write", bus.mem_write, (m_owner != OwnNone) && m_wr);
            if (m_owner != OwnNone) begin
                chka("rnd_mem_address", bus.mem_address, m_addr);
                if (m_wr) chkw("rnd_mem_wdata", bus.mem_wdata, m_wdata);
            end
            chk1("rnd_i_resp", bus.i_resp, resp_now && ((m_owner == OwnI) || merge));
            chk1("rnd_d_resp", bus.d_resp, resp_now && (m_owner == OwnD));
            chk1("rnd_p_resp", bus.p_resp, resp_now && (m_owner == OwnP));
            if (resp_now && !m_wr) begin
                if (m_owner == OwnI || merge) chkw("rnd_i_rdata", bus.i_rdata, phys_rd(m_addr));
                if (m_owner == OwnD) chkw("rnd_d_rdata", bus.d_rdata, phys_rd(m_addr));
                if (m_owner == OwnP) chkw("rnd_p_rdata", bus.p_rdata, phys_rd(m_addr));
            end

            if (g != OwnNone) begin
                m_owner = g;
                m_cnt   = $urandom_range(0, 3);
                case (g)
                    OwnI: begin m_addr = ia; m_wr = 1'b0; end
                    OwnD: begin m_addr = da; m_wr = dw; m_wdata = dwd; end
                    default: begin m_addr = pa; m_wr = 1'b0; pp = 1'b0; end
                endcase
            end else if (m_rel) begin
                m_rel = 1'b0;
            end else if (m_owner != OwnNone) begin
                if (resp_now) begin
                    if (m_owner == OwnI) m_last_d = 1'b0;
                    if (m_owner == OwnD) begin
                        m_last_d = 1'b1;
                        if (m_wr) phys[m_addr] = m_wdata;
                    end
                    if (m_owner == OwnI || merge) ip = 1'b0;
                    if (m_owner == OwnD) dp = 1'b0;
                    m_owner = OwnNone;
                    m_rel   = 1'b1;
                end else begin
                    m_cnt--;
                end
            end

            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1'b1;
                ia = pick();
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp  = 1'b1;
                dw  = 1'($urandom_range(0, 1));
                da  = pick();
                dwd = {8{$urandom}};
            end
            if (pp && $urandom_range(0, 7) == 0) begin
                pp = 1'b0;
            end else if (!pp && $urandom_range(0, 3) == 0) begin
                pp = 1'b1;
                pa = pick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
